// File: rtl/exec_stage_mc_pkg.sv
// Shared definitions for the multi-cycle execute stage: opcodes, ALU operations,
// branch conditions, the link register index and the control FSM states.
package exec_stage_mc_pkg;

    localparam logic [3:0] OP_REG_ADD_IMM8      = 4'd0;
    localparam logic [3:0] OP_REG_MOV_IMM11     = 4'd1;
    localparam logic [3:0] OP_REG_MOV_IMM11_TOP = 4'd2;
    localparam logic [3:0] OP_LOAD_FROM_MEMORY  = 4'd3;
    localparam logic [3:0] OP_WRITE_TO_MEMORY   = 4'd4;
    localparam logic [3:0] OP_ALU               = 4'd5;
    localparam logic [3:0] OP_IF                = 4'd6;
    localparam logic [3:0] OP_CALL_IMM14        = 4'd7;
    localparam logic [3:0] OP_RETURN            = 4'd8;
    localparam logic [3:0] OP_MUL_SHIFT         = 4'd9;
    localparam logic [3:0] OP_WAIT              = 4'd10;

    localparam logic [3:0] ALU_OP_ADD = 4'd0;
    localparam logic [3:0] ALU_OP_SUB = 4'd1;
    localparam logic [3:0] ALU_OP_AND = 4'd2;
    localparam logic [3:0] ALU_OP_OR  = 4'd3;
    localparam logic [3:0] ALU_OP_XOR = 4'd4;
    localparam logic [3:0] ALU_OP_NOT = 4'd5;
    localparam logic [3:0] ALU_OP_SHL = 4'd6;
    localparam logic [3:0] ALU_OP_SHR = 4'd7;
    localparam logic [3:0] ALU_OP_MOV = 4'd8;

    localparam logic [2:0] IF_COND_ZERO     = 3'd0;
    localparam logic [2:0] IF_COND_NONZERO  = 3'd1;
    localparam logic [2:0] IF_COND_NEG      = 3'd2;
    localparam logic [2:0] IF_COND_NONNEG   = 3'd3;

    localparam logic [2:0] LINK_REG = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/mulxx_seq.sv
// Iterative unsigned multiplier retiring MUL_BITS multiplier bits per cycle.
// done is high during the last step and product then already holds the final sum.
module mulxx_seq #(
    parameter int WORD_SIZE = 18,
    parameter int MUL_BITS  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WORD_SIZE-1:0]     a,
    input  logic [WORD_SIZE-1:0]     b,
    output logic                     done,
    output logic [2*WORD_SIZE-1:0]   product
);

    localparam int STEPS = WORD_SIZE / MUL_BITS;
    localparam int CNT_W = $clog2(STEPS + 1);

    logic [2*WORD_SIZE-1:0] mcand_q, mcand_d;
    logic [WORD_SIZE-1:0]   mplier_q, mplier_d;
    logic [2*WORD_SIZE-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WORD_SIZE-1:0] partial;
    logic [2*WORD_SIZE-1:0] sum;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        partial  = mcand_q * {{(2*WORD_SIZE-MUL_BITS){1'b0}}, mplier_q[MUL_BITS-1:0]};
        sum      = acc_q + partial;
        if (start) begin
            mcand_d  = {{WORD_SIZE{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CNT_W'(STEPS);
        end else if (cnt_q != '0) begin
            mcand_d  = mcand_q << MUL_BITS;
            mplier_d = mplier_q >> MUL_BITS;
            acc_d    = sum;
            cnt_d    = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign done    = (cnt_q == CNT_W'(1));
    assign product = sum;

endmodule

// File: rtl/exec_stage_mc.sv
// Execute stage: single-cycle register/branch ops, an iterative MUL_SHIFT and a
// WAIT stall, with registered writeback and jump outputs.
module exec_stage_mc
    import exec_stage_mc_pkg::*;
#(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = 18,
    parameter int MUL_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] code_word,
    input  logic [WORD_SIZE-1:0] alu_data0,
    input  logic [WORD_SIZE-1:0] alu_data1,
    input  logic [WORD_SIZE-1:0] data1_plus_imm8,
    input  logic [WORD_SIZE-1:0] memory_out,
    input  logic [ADDR_SIZE-1:0] ip,
    input  logic [ADDR_SIZE-1:0] ip_plus_one,
    output logic                 reg_write_enable,
    output logic [2:0]           reg_write_addr,
    output logic [WORD_SIZE-1:0] reg_write_data,
    output logic                 jump_valid,
    output logic [ADDR_SIZE-1:0] jump_addr,
    output logic                 busy
);

    state_e state_q, state_d;
    logic [10:0] wait_cnt_q, wait_cnt_d;
    logic [4:0]  shift_q, shift_d;
    logic [2:0]  mul_rx_q, mul_rx_d;

    logic                 reg_write_enable_q, reg_write_enable_d;
    logic [2:0]           reg_write_addr_q, reg_write_addr_d;
    logic [WORD_SIZE-1:0] reg_write_data_q, reg_write_data_d;
    logic                 jump_valid_q, jump_valid_d;
    logic [ADDR_SIZE-1:0] jump_addr_q, jump_addr_d;

    logic [3:0]  op;
    logic [2:0]  rx;
    logic [7:0]  imm8;
    logic [10:0] imm11;
    logic [2:0]  cond;
    logic [3:0]  alu_op;
    logic        accept;
    logic        branch_taken;
    logic [WORD_SIZE-1:0]   alu_result;
    logic                   mul_done;
    logic [2*WORD_SIZE-1:0] mul_product;

    assign op     = code_word[WORD_SIZE-1:WORD_SIZE-4];
    assign rx     = code_word[WORD_SIZE-5:WORD_SIZE-7];
    assign imm8   = code_word[7:0];
    assign imm11  = code_word[10:0];
    assign cond   = code_word[10:8];
    assign alu_op = code_word[3:0];

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q == ST_MUL) || (state_q == ST_WAIT);
    assign accept   = in_valid && in_ready;

    mulxx_seq #(
        .WORD_SIZE (WORD_SIZE),
        .MUL_BITS  (MUL_BITS)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && (op == OP_MUL_SHIFT)),
        .a       (alu_data0),
        .b       (alu_data1),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        case (alu_op)
            ALU_OP_ADD: alu_result = alu_data0 + alu_data1;
            ALU_OP_SUB: alu_result = alu_data0 - alu_data1;
            ALU_OP_AND: alu_result = alu_data0 & alu_data1;
            ALU_OP_OR:  alu_result = alu_data0 | alu_data1;
            ALU_OP_XOR: alu_result = alu_data0 ^ alu_data1;
            ALU_OP_NOT: alu_result = ~alu_data0;
            ALU_OP_SHL: alu_result = alu_data0 << 1;
            ALU_OP_SHR: alu_result = alu_data0 >> 1;
            ALU_OP_MOV: alu_result = alu_data1;
            default:    alu_result = '0;
        endcase
    end

    // Branch conditions test the rx register value, which arrives as alu_data0.
    always_comb begin
        case (cond)
            IF_COND_ZERO:    branch_taken = (alu_data0 == '0);
            IF_COND_NONZERO: branch_taken = (alu_data0 != '0);
            IF_COND_NEG:     branch_taken = alu_data0[WORD_SIZE-1];
            IF_COND_NONNEG:  branch_taken = !alu_data0[WORD_SIZE-1];
            default:         branch_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            shift_q    <= '0;
            mul_rx_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            shift_q    <= shift_d;
            mul_rx_q   <= mul_rx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        shift_d    = shift_q;
        mul_rx_d   = mul_rx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && op == OP_MUL_SHIFT) begin
                    state_d  = ST_MUL;
                    shift_d  = code_word[4:0];
                    mul_rx_d = rx;
                end else if (accept && op == OP_WAIT && imm11 != '0) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = imm11;
                end
            end
            ST_MUL: begin
                if (mul_done) state_d = ST_IDLE;
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - 11'd1;
                if (wait_cnt_q == 11'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address and data outputs hold their last value when nothing is written.
    always_comb begin
        reg_write_enable_d = 1'b0;
        reg_write_addr_d   = reg_write_addr_q;
        reg_write_data_d   = reg_write_data_q;
        jump_valid_d       = 1'b0;
        jump_addr_d        = jump_addr_q;
        if (state_q == ST_MUL && mul_done) begin
            reg_write_enable_d = 1'b1;
            reg_write_addr_d   = mul_rx_q;
            reg_write_data_d   = WORD_SIZE'(mul_product >> shift_q);
        end else if (accept) begin
            case (op)
                OP_REG_ADD_IMM8: begin
                    reg_write_enable_d = 1'b1;
                    reg_write_addr_d   = rx;
                    reg_write_data_d   = data1_plus_imm8;
                end
                OP_REG_MOV_IMM11: begin
                    reg_write_enable_d = 1'b1;
                    reg_write_addr_d   = rx;
                    reg_write_data_d   = WORD_SIZE'($signed(imm11));
                end
                OP_REG_MOV_IMM11_TOP: begin
                    reg_write_enable_d = 1'b1;
                    reg_write_addr_d   = rx;
                    reg_write_data_d   = WORD_SIZE'({imm11, 7'b0});
                end
                OP_LOAD_FROM_MEMORY: begin
                    reg_write_enable_d = 1'b1;
                    reg_write_addr_d   = rx;
                    reg_write_data_d   = memory_out;
                end
                OP_ALU: begin
                    reg_write_enable_d = 1'b1;
                    reg_write_addr_d   = rx;
                    reg_write_data_d   = alu_result;
                end
                OP_IF: begin
                    if (branch_taken) begin
                        jump_valid_d = 1'b1;
                        jump_addr_d  = ip + ADDR_SIZE'($signed(imm8));
                    end
                end
                OP_CALL_IMM14: begin
                    jump_valid_d       = 1'b1;
                    jump_addr_d        = ADDR_SIZE'(code_word[13:0]);
                    reg_write_enable_d = 1'b1;
                    reg_write_addr_d   = LINK_REG;
                    reg_write_data_d   = WORD_SIZE'(ip_plus_one);
                end
                OP_RETURN: begin
                    jump_valid_d = 1'b1;
                    jump_addr_d  = memory_out[ADDR_SIZE-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_enable_q <= 1'b0;
            reg_write_addr_q   <= '0;
            reg_write_data_q   <= '0;
            jump_valid_q       <= 1'b0;
            jump_addr_q        <= '0;
        end else begin
            reg_write_enable_q <= reg_write_enable_d;
            reg_write_addr_q   <= reg_write_addr_d;
            reg_write_data_q   <= reg_write_data_d;
            jump_valid_q       <= jump_valid_d;
            jump_addr_q        <= jump_addr_d;
        end
    end

    assign reg_write_enable = reg_write_enable_q;
    assign reg_write_addr   = reg_write_addr_q;
    assign reg_write_data   = reg_write_data_q;
    assign jump_valid       = jump_valid_q;
    assign jump_addr        = jump_addr_q;

endmodule

// File: tb/tb_exec_stage_mc.sv
// Directed plus randomized bench for exec_stage_mc, checked against an
// arithmetic reference model of each instruction's outcome and stall length.
module tb_exec_stage_mc;
    import exec_stage_mc_pkg::*;

    localparam int W     = 18;
    localparam int A     = 18;
    localparam int MB    = 2;
    localparam int STEPS = W / MB;
    localparam longint WMOD = 64'd1 << W;
    localparam longint AMOD = 64'd1 << A;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] code_word = '0;
    logic [W-1:0] alu_data0 = '0;
    logic [W-1:0] alu_data1 = '0;
    logic [W-1:0] data1_plus_imm8 = '0;
    logic [W-1:0] memory_out = '0;
    logic [A-1:0] ip = '0;
    logic [A-1:0] ip_plus_one = '0;
    logic         reg_write_enable;
    logic [2:0]   reg_write_addr;
    logic [W-1:0] reg_write_data;
    logic         jump_valid;
    logic [A-1:0] jump_addr;
    logic         busy;

    int total = 0;
    int bad   = 0;

    exec_stage_mc #(.ADDR_SIZE(A), .WORD_SIZE(W), .MUL_BITS(MB)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .code_word        (code_word),
        .alu_data0        (alu_data0),
        .alu_data1        (alu_data1),
        .data1_plus_imm8  (data1_plus_imm8),
        .memory_out       (memory_out),
        .ip               (ip),
        .ip_plus_one      (ip_plus_one),
        .reg_write_enable (reg_write_enable),
        .reg_write_addr   (reg_write_addr),
        .reg_write_data   (reg_write_data),
        .jump_valid       (jump_valid),
        .jump_addr        (jump_addr),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit     we;
        longint addr;
        longint data;
        bit     jv;
        longint jaddr;
        int     stall;
    } exp_t;

    function automatic longint alu_model(input logic [3:0] f, input longint a, input longint b);
        case (f)
            ALU_OP_ADD: return (a + b) % WMOD;
            ALU_OP_SUB: return (a - b + WMOD) % WMOD;
            ALU_OP_AND: return a & b;
            ALU_OP_OR:  return a | b;
            ALU_OP_XOR: return a ^ b;
            ALU_OP_NOT: return WMOD - 1 - a;
            ALU_OP_SHL: return (a * 2) % WMOD;
            ALU_OP_SHR: return a / 2;
            ALU_OP_MOV: return b;
            default:    return 0;
        endcase
    endfunction

    function automatic exp_t model(input logic [W-1:0] cw, input longint d0, input longint d1,
                                   input longint d1pi, input longint mem, input longint ipv,
                                   input longint ipp1);
        exp_t   e;
        longint imm8  = longint'(cw[7:0]);
        longint imm11 = longint'(cw[10:0]);
        longint cnd   = longint'(cw[10:8]);
        longint off;
        bit     taken;
        e = '{default: 0};
        e.addr = longint'(cw[13:11]);
        case (cw[17:14])
            OP_REG_ADD_IMM8:      begin e.we = 1; e.data = d1pi; end
            OP_REG_MOV_IMM11:     begin e.we = 1; e.data = (imm11 >= 1024) ? imm11 - 2048 + WMOD : imm11; end
            OP_REG_MOV_IMM11_TOP: begin e.we = 1; e.data = imm11 * 128; end
            OP_LOAD_FROM_MEMORY:  begin e.we = 1; e.data = mem; end
            OP_ALU:               begin e.we = 1; e.data = alu_model(cw[3:0], d0, d1); end
            OP_IF: begin
                taken = (cnd == 0 && d0 == 0) || (cnd == 1 && d0 != 0) ||
                        (cnd == 2 && d0 >= WMOD / 2) || (cnd == 3 && d0 < WMOD / 2);
                off = (imm8 >= 128) ? imm8 - 256 : imm8;
                e.jv = taken;
                e.jaddr = (ipv + off + AMOD) % AMOD;
            end
            OP_CALL_IMM14: begin
                e.jv = 1; e.jaddr = longint'(cw[13:0]);
                e.we = 1; e.addr = 7; e.data = ipp1;
            end
            OP_RETURN: begin e.jv = 1; e.jaddr = mem % AMOD; end
            OP_MUL_SHIFT: begin
                e.stall = STEPS;
                e.we = 1;
                e.data = ((d0 * d1) >> cw[4:0]) % WMOD;
            end
            OP_WAIT: e.stall = int'(imm11);
            default: ;
        endcase
        return e;
    endfunction

    // Issue one instruction from IDLE, hold in_valid with junk inputs while the stage stalls,
    // then check the single registered result cycle.
    task automatic run_instr(input string name, input logic [W-1:0] cw, input logic [W-1:0] d0,
                             input logic [W-1:0] d1, input logic [W-1:0] d1pi,
                             input logic [W-1:0] mem, input logic [A-1:0] ipv,
                             input logic [A-1:0] ipp1);
        exp_t e;
        e = model(cw, longint'(d0), longint'(d1), longint'(d1pi), longint'(mem),
                  longint'(ipv), longint'(ipp1));
        check({name, ".ready"}, in_ready, 1);
        code_word = cw; alu_data0 = d0; alu_data1 = d1; data1_plus_imm8 = d1pi;
        memory_out = mem; ip = ipv; ip_plus_one = ipp1; in_valid = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < e.stall; c++) begin
            check({name, ".stall_ready"}, in_ready, 0);
            check({name, ".stall_busy"}, busy, 1);
            check({name, ".stall_we"}, reg_write_enable, 0);
            check({name, ".stall_jv"}, jump_valid, 0);
            code_word = W'($urandom); alu_data0 = W'($urandom); alu_data1 = W'($urandom);
            data1_plus_imm8 = W'($urandom); memory_out = W'($urandom);
            ip = A'($urandom); ip_plus_one = A'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check({name, ".busy"}, busy, 0);
        check({name, ".we"}, reg_write_enable, 64'(e.we));
        check({name, ".jv"}, jump_valid, 64'(e.jv));
        if (e.we) begin
            check({name, ".waddr"}, reg_write_addr, 64'(e.addr));
            check({name, ".wdata"}, reg_write_data, 64'(e.data));
        end
        if (e.jv) check({name, ".jaddr"}, jump_addr, 64'(e.jaddr));
    endtask

    task automatic idle_cycle(input string name);
        @(posedge clk); #1;
        check({name, ".idle_we"}, reg_write_enable, 0);
        check({name, ".idle_jv"}, jump_valid, 0);
    endtask

    initial begin
        logic [3:0]   rop;
        logic [W-1:0] rcw;
        logic [W-1:0] rd0;

        #1;
        check("reset.we", reg_write_enable, 0);
        check("reset.jv", jump_valid, 0);
        check("reset.waddr", reg_write_addr, 0);
        check("reset.wdata", reg_write_data, 0);
        check("reset.jaddr", jump_addr, 0);
        check("reset.busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset.ready", in_ready, 1);

        run_instr("t1_mov", {OP_REG_MOV_IMM11, 3'd3, 11'h7FF}, '0, '0, '0, '0, '0, '0);
        check("t1_lit_data", reg_write_data, 64'h3FFFF);
        idle_cycle("t1");
        run_instr("t2_mul", {OP_MUL_SHIFT, 3'd2, 6'd0, 5'd4}, W'(300), W'(500), '0, '0, '0, '0);
        check("t2_lit_data", reg_write_data, 64'd9375);
        idle_cycle("t2");
        run_instr("t3_if_taken", {OP_IF, 3'd1, 3'd0, 8'hFE}, '0, '0, '0, '0, A'(18'h10), '0);
        check("t3_lit_jaddr", jump_addr, 64'hE);
        idle_cycle("t3a");
        run_instr("t3_if_not", {OP_IF, 3'd1, 3'd0, 8'hFE}, W'(5), '0, '0, '0, A'(18'h10), '0);
        idle_cycle("t3b");
        run_instr("t4_call", {OP_CALL_IMM14, 14'h1234}, '0, '0, '0, '0, A'(18'h20), A'(18'h21));
        idle_cycle("t4");
        run_instr("t5_wait", {OP_WAIT, 3'd0, 11'd5}, '0, '0, '0, '0, '0, '0);
        run_instr("t5_next", {OP_LOAD_FROM_MEMORY, 3'd4, 11'd0}, '0, '0, '0, W'(18'h2ABCD), '0, '0);
        run_instr("wait0_nop", {OP_WAIT, 3'd0, 11'd0}, '0, '0, '0, '0, '0, '0);
        run_instr("mov_min", {OP_REG_MOV_IMM11, 3'd1, 11'h400}, '0, '0, '0, '0, '0, '0);
        run_instr("mov_top", {OP_REG_MOV_IMM11_TOP, 3'd6, 11'h7FF}, '0, '0, '0, '0, '0, '0);
        run_instr("if_wrap", {OP_IF, 3'd0, 3'd2, 8'h80}, W'(18'h20000), '0, '0, '0, A'(18'h10), '0);
        run_instr("mem_write", {OP_WRITE_TO_MEMORY, 3'd2, 11'h123}, '1, '1, '1, '1, '1, '1);
        run_instr("undef_op", {4'd15, 3'd5, 11'h3FF}, '1, '1, '1, '1, '1, '1);
        idle_cycle("t_misc");

        // Reset in the fourth multiply cycle must abort the writeback.
        code_word = {OP_MUL_SHIFT, 3'd3, 6'd0, 5'd0};
        alu_data0 = W'(1234); alu_data1 = W'(777); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c < 4; c++) begin
            @(posedge clk); #1;
        end
        check("t6_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_ready_after", in_ready, 1);
        for (int c = 0; c < 12; c++) begin
            check("t6_no_we", reg_write_enable, 0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            rcw = {rop, 14'($urandom)};
            if (rop == OP_WAIT) rcw[10:0] = 11'($urandom_range(0, 6));
            rd0 = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            run_instr("rand", rcw, rd0, W'($urandom), W'($urandom), W'($urandom),
                      A'($urandom), A'($urandom));
            if ($urandom_range(0, 1) == 1) idle_cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_stage_mc.md
EXEC_STAGE_MC -- requirements
Module: exec_stage_mc

Interface
REQ-001 Parameter ADDR_SIZE, default 18, instruction address width.
REQ-002 Parameter WORD_SIZE, default 18, data/code word width; SHALL be at least 18.
REQ-003 Parameter MUL_BITS, default 2, multiplier bits consumed per cycle; SHALL divide WORD_SIZE.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  decoded instruction present on the inputs below.
REQ-007 in_ready  out  1  stage accepts an instruction this cycle.
REQ-008 code_word  in  WORD_SIZE  instruction word.
REQ-009 alu_data0 and alu_data1  in  WORD_SIZE  operands, rx value and ry value.
REQ-010 data1_plus_imm8  in  WORD_SIZE  ry + imm8 precomputed upstream.
REQ-011 memory_out  in  WORD_SIZE  memory read data for the current instruction.
REQ-012 ip and ip_plus_one  in  ADDR_SIZE  address of the instruction and its successor.
REQ-013 reg_write_enable  out  1; reg_write_addr  out  3; reg_write_data  out  WORD_SIZE; all registered.
REQ-014 jump_valid  out  1; jump_addr  out  ADDR_SIZE; both registered, one-cycle pulse.
REQ-015 busy  out  1  high while in MUL or WAIT state.

Function
REQ-016 Fields: op = code_word[WORD_SIZE-1:WORD_SIZE-4]; rx = code_word[WORD_SIZE-5:WORD_SIZE-7]; imm8 = code_word[7:0]; imm11 = code_word[10:0].
REQ-017 FSM states are IDLE, MUL and WAIT; in_ready SHALL be 1 only in IDLE.
REQ-018 An instruction SHALL be accepted when in_valid and in_ready; inputs are sampled only at acceptance.
REQ-019 Single-cycle ops SHALL produce outputs on the cycle after acceptance (latency 1), with reg_write_addr = rx.
REQ-020 Write data: OP_REG_ADD_IMM8 = data1_plus_imm8; OP_REG_MOV_IMM11 = sign-extended imm11; OP_REG_MOV_IMM11_TOP = imm11 followed by 7 zero bits, zero-extended above; OP_LOAD_FROM_MEMORY = memory_out; OP_ALU = alu result with op code_word[3:0].
REQ-021 OP_WRITE_TO_MEMORY SHALL produce no register write and no jump.
REQ-022 OP_IF: cond = code_word[10:8]; 0 means rx==0, 1 means rx!=0, 2 means rx MSB=1, 3 means rx MSB=0, and 4-7 are never taken. A taken branch gives jump_addr = ip + sign-extended imm8, modulo 2^ADDR_SIZE.
REQ-023 OP_CALL_IMM14: jump_addr = zero-extended code_word[13:0]; register LINK_REG is written with ip_plus_one in the same cycle.
REQ-024 OP_RETURN: jump_addr = memory_out[ADDR_SIZE-1:0]; no register write.
REQ-025 OP_MUL_SHIFT: latch the operands and shift = code_word[4:0], then enter MUL.
REQ-026 MUL lasts WORD_SIZE/MUL_BITS cycles and forms an unsigned 2*WORD_SIZE product.
REQ-027 On the final MUL cycle, the next edge SHALL pulse reg_write_enable, with data = (product >> shift)[WORD_SIZE-1:0], and return to IDLE. Total latency from acceptance = WORD_SIZE/MUL_BITS + 1 cycles.
REQ-028 OP_WAIT: imm11 == 0 behaves as a 1-cycle NOP; otherwise the block enters WAIT for imm11 cycles, then returns to IDLE with no writes.
REQ-029 Undefined opcodes, or cycles without acceptance, SHALL leave reg_write_enable=0 and jump_valid=0 on the following cycle.
REQ-030 in_valid while in_ready=0 SHALL be ignored; upstream holds the instruction.
REQ-031 reg_write_enable and jump_valid SHALL each be high for exactly one cycle per causing instruction.

Reset
REQ-032 On reset low: state=IDLE; reg_write_enable=0; jump_valid=0; reg_write_addr=0; reg_write_data=0; jump_addr=0; busy=0; counters=0.
REQ-033 Reset asserted mid-MUL or mid-WAIT SHALL abort the operation with no later writeback.
REQ-034 in_ready SHALL be 1 on the first edge after reset deasserts.

Structure
REQ-035 The shared package SHALL hold: opcode constants (OP_*), ALU_OP_* constants, IF condition codes, LINK_REG (= 7) and the FSM state enum.
REQ-036 The iterative multiplier SHALL be a sub-module named mulxx_seq, with start/done handshake and parameters WORD_SIZE and MUL_BITS; the combinational alu is reused.

Verification
REQ-037 Test 1: reset, then OP_REG_MOV_IMM11 rx=3 imm11=0x7FF -> next cycle reg_write_enable=1, addr=3, data=0x3FFFF.
REQ-038 Test 2: OP_MUL_SHIFT with alu_data0=300, alu_data1=500, shift=4 -> in_ready low 9 cycles; a single write of 9375 on cycle 10.
REQ-039 Test 3: OP_IF cond=0, rx=0, ip=0x00010, imm8=0xFE -> jump_valid pulse with jump_addr=0x0000E; with rx=5 -> no jump.
REQ-040 Test 4: OP_CALL_IMM14 imm14=0x1234, ip_plus_one=0x21 -> jump_addr=0x1234, write addr=7 data=0x21, same cycle.
REQ-041 Test 5: OP_WAIT imm11=5 with in_valid held high -> busy 5 cycles, the next instruction is accepted on cycle 6.
REQ-042 Test 6: reset pulsed on MUL cycle 4 -> no reg_write_enable afterwards, in_ready=1 after release.
